wb_rr_arbiter: RTL



---
 rtl/wb_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter.
// Round-robin ownership per bus cycle, with an outstanding-request limit.
module wb_rr_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LGDEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_a_cyc,
    input  logic               i_a_stb,
    input  logic               i_a_we,
    input  logic [AW-1:0]      i_a_addr,
    input  logic [DW-1:0]      i_a_data,
    input  logic [DW/8-1:0]    i_a_sel,
    output logic               o_a_stall,
    output logic               o_a_ack,
    output logic               o_a_err,
    output logic [DW-1:0]      o_a_data,
    input  logic               i_b_cyc,
    input  logic               i_b_stb,
    input  logic               i_b_we,
    input  logic [AW-1:0]      i_b_addr,
    input  logic [DW-1:0]      i_b_data,
    input  logic [DW/8-1:0]    i_b_sel,
    output logic               o_b_stall,
    output logic               o_b_ack,
    output logic               o_b_err,
    output logic [DW-1:0]      o_b_data,
    output logic               o_m_cyc,
    output logic               o_m_stb,
    output logic               o_m_we,
    output logic [AW-1:0]      o_m_addr,
    output logic [DW-1:0]      o_m_data,
    output logic [DW/8-1:0]    o_m_sel,
    input  logic               i_m_stall,
    input  logic               i_m_ack,
    input  logic               i_m_err,
    input  logic [DW-1:0]      i_m_data,
    output logic [1:0]         o_owner,
    output logic [LGDEPTH-1:0] o_outstanding
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [LGDEPTH-1:0] MAX = '1;

    state_t             state;
    logic               prio;
    logic [LGDEPTH-1:0] count;

    logic gnt_a, gnt_b, m_cyc, ret, full, inc, dec, stb;

    assign gnt_a = (state == GRANT_A);
    assign gnt_b = (state == GRANT_B);
    assign m_cyc = (gnt_a & i_a_cyc) | (gnt_b & i_b_cyc);
    assign ret   = i_m_ack | i_m_err;
    // A same-cycle return frees a slot, so issue may proceed at the limit.
    assign full  = (count == MAX) & ~ret;
    assign stb   = (gnt_a & i_a_stb) | (gnt_b & i_b_stb);

    assign o_m_cyc = m_cyc;
    assign o_m_stb = stb & m_cyc & ~full;

    always_comb begin
        o_m_we   = 1'b0;
        o_m_addr = '0;
        o_m_data = '0;
        o_m_sel  = '0;
        unique case (1'b1)
            gnt_a: begin
                o_m_we   = i_a_we;
                o_m_addr = i_a_addr;
                o_m_data = i_a_data;
                o_m_sel  = i_a_sel;
            end
            gnt_b: begin
                o_m_we   = i_b_we;
                o_m_addr = i_b_addr;
                o_m_data = i_b_data;
                o_m_sel  = i_b_sel;
            end
            default: ;
        endcase
    end

    assign o_a_stall = ~gnt_a | i_m_stall | full;
    assign o_b_stall = ~gnt_b | i_m_stall | full;
    assign o_a_ack   = gnt_a & m_cyc & i_m_ack;
    assign o_a_err   = gnt_a & m_cyc & i_m_err;
    assign o_b_ack   = gnt_b & m_cyc & i_m_ack;
    assign o_b_err   = gnt_b & m_cyc & i_m_err;
    assign o_a_data  = i_m_data;
    assign o_b_data  = i_m_data;

    assign o_owner       = {gnt_b, gnt_a};
    assign o_outstanding = count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_a_cyc && (!i_b_cyc || !prio))
                        state <= GRANT_A;
                    else if (i_b_cyc)
                        state <= GRANT_B;
                end
                GRANT_A: begin
                    if (!i_a_cyc) begin
                        state <= i_b_cyc ? GRANT_B : IDLE;
                        prio  <= 1'b1;
                    end
                end
                GRANT_B: begin
                    if (!i_b_cyc) begin
                        state <= i_a_cyc ? GRANT_A : IDLE;
                        prio  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign inc = o_m_stb & ~i_m_stall;
    assign dec = m_cyc & ret;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            count <= '0;
        else if (!m_cyc)
            count <= '0;
        else if (inc && !dec)
            count <= count + 1'b1;
        else if (dec && !inc)
            count <= count - 1'b1;
    end

endmodule
